// File: rtl/ksa4_cap_pkg.sv
// Shared types and helpers for the KSA4 result-capture block: result width,
// FSM state encoding, operand bundle and the reference 4-bit sum.
package ksa4_cap_pkg;

  localparam int RES_W = 5;

  typedef logic [RES_W-1:0] result_t;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
  } operand_t;

  // Reference result {cout,sum[3:0]} of a 4-bit add with carry-in.
  function automatic result_t exp_sum(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    return result_t'(a) + result_t'(b) + result_t'(cin);
  endfunction

endpackage

// File: rtl/ksa4_cap_fifo.sv
// First-word-fall-through FIFO. The head entry is visible on data_o while not
// empty. Pointers carry an extra wrap bit so full and empty are distinguishable.
module ksa4_cap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ksa4_result_capture.sv
// Result capture for the 4-bit Kogge-Stone adder: aligns result bits with a
// delayed valid tag, suppresses them during warm-up and queues them in a FWFT
// FIFO. Define KSA4_CAP_CHECK_EN to add the operand-based result checker.
module ksa4_result_capture
  import ksa4_cap_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             GCLK_Pad,
  input  logic             RST_Pad,
  input  logic             in_valid_Pad,
  input  logic             sum0_Pad,
  input  logic             sum1_Pad,
  input  logic             sum2_Pad,
  input  logic             sum3_Pad,
  input  logic             cout_Pad,
  input  logic             rd_en_Pad,
`ifdef KSA4_CAP_CHECK_EN
  input  logic [3:0]       a_Pad,
  input  logic [3:0]       b_Pad,
  input  logic [0:0]       cin_Pad,
  output logic             mism_Pad,
  output logic [7:0]       mism_cnt_Pad,
`endif
  output logic             rd_valid_Pad,
  output logic [RES_W-1:0] rd_data_Pad,
  output logic             full_Pad,
  output logic             overflow_Pad,
  output logic             ready_Pad,
  output logic [7:0]       res_cnt_Pad
);

  state_t                state_q, state_d;
  logic [7:0]            warm_q, warm_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_full, fifo_empty;
  logic                  wr_req, rd_pop, push, drop;
  result_t               res;

  assign res = {cout_Pad, sum3_Pad, sum2_Pad, sum1_Pad, sum0_Pad};

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      state_q <= WARM;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      WARM: begin
        warm_d = warm_q + 8'd1;
        if (warm_q == 8'(WARMUP - 1)) state_d = RUN;
      end
      RUN: state_d = RUN;
    endcase
  end

  always_comb begin
    ready_Pad = (state_q == RUN);
  end

  // Valid tag shifts in both states; the last stage lines up with the result.
  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid_Pad;
    for (int i = 1; i < PIPE_DEPTH; i++) vld_d[i] = vld_q[i-1];
  end

  assign wr_req = (state_q == RUN) && vld_q[PIPE_DEPTH-1];
  assign rd_pop = rd_en_Pad && !fifo_empty;
  assign push   = wr_req && (!fifo_full || rd_pop);
  assign drop   = wr_req && !push;

  assign cnt_d = push ? cnt_q + 8'd1 : cnt_q;
  assign ovf_d = ovf_q | drop;

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      vld_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  ksa4_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk_i   (GCLK_Pad),
    .rst_i   (RST_Pad),
    .push_i  (push),
    .pop_i   (rd_pop),
    .data_i  (res),
    .data_o  (rd_data_Pad),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_valid_Pad = !fifo_empty;
  assign full_Pad     = fifo_full;
  assign overflow_Pad = ovf_q;
  assign res_cnt_Pad  = cnt_q;

`ifdef KSA4_CAP_CHECK_EN
  operand_t   op_q [PIPE_DEPTH];
  operand_t   op_d [PIPE_DEPTH];
  logic       mism_q, mism_d;
  logic [7:0] mism_cnt_q, mism_cnt_d;

  // Operands travel alongside the valid tag; dropped writes are still checked.
  always_comb begin
    op_d    = op_q;
    op_d[0] = {a_Pad, b_Pad, cin_Pad};
    for (int i = 1; i < PIPE_DEPTH; i++) op_d[i] = op_q[i-1];
    mism_d = wr_req && (res != exp_sum(op_q[PIPE_DEPTH-1].a, op_q[PIPE_DEPTH-1].b,
                                       op_q[PIPE_DEPTH-1].cin));
    mism_cnt_d = mism_cnt_q;
    if (mism_d && (mism_cnt_q != 8'hFF)) mism_cnt_d = mism_cnt_q + 8'd1;
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      op_q       <= '{default: '0};
      mism_q     <= 1'b0;
      mism_cnt_q <= '0;
    end else begin
      op_q       <= op_d;
      mism_q     <= mism_d;
      mism_cnt_q <= mism_cnt_d;
    end
  end

  assign mism_Pad     = mism_q;
  assign mism_cnt_Pad = mism_cnt_q;
`endif

endmodule

// File: tb/tb_ksa4_result_capture.sv
// Directed self-checking bench for ksa4_result_capture (PIPE_DEPTH=4,
// WARMUP=20, FIFO_DEPTH=8); covers the checker when KSA4_CAP_CHECK_EN is set.
`timescale 1ns/1ps
module tb_ksa4_result_capture;
  import ksa4_cap_pkg::*;

  localparam int PIPE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       rd_en = 1'b0;
  result_t    res_in = '0;
  logic       rd_valid, full, overflow, ready;
  result_t    rd_data;
  logic [7:0] res_cnt;
`ifdef KSA4_CAP_CHECK_EN
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic [0:0] cin_in = '0;
  logic       mism;
  logic [7:0] mism_cnt;
`endif

  int checks = 0;
  int failures = 0;
  result_t drain_exp [8] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10};

  always #5 clk = ~clk;

  ksa4_result_capture #(
    .PIPE_DEPTH (PIPE),
    .WARMUP     (20),
    .FIFO_DEPTH (8)
  ) dut (
    .GCLK_Pad     (clk),
    .RST_Pad      (rst),
    .in_valid_Pad (in_valid),
    .sum0_Pad     (res_in[0]),
    .sum1_Pad     (res_in[1]),
    .sum2_Pad     (res_in[2]),
    .sum3_Pad     (res_in[3]),
    .cout_Pad     (res_in[4]),
    .rd_en_Pad    (rd_en),
`ifdef KSA4_CAP_CHECK_EN
    .a_Pad        (a_in),
    .b_Pad        (b_in),
    .cin_Pad      (cin_in),
    .mism_Pad     (mism),
    .mism_cnt_Pad (mism_cnt),
`endif
    .rd_valid_Pad (rd_valid),
    .rd_data_Pad  (rd_data),
    .full_Pad     (full),
    .overflow_Pad (overflow),
    .ready_Pad    (ready),
    .res_cnt_Pad  (res_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tag at edge k, result bits presented for edge k+PIPE.
  task automatic inject(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input bit force_en, input result_t force_val);
`ifdef KSA4_CAP_CHECK_EN
    a_in   = a;
    b_in   = b;
    cin_in = cin;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (PIPE - 1) tick();
    res_in = force_en ? force_val : exp_sum(a, b, cin);
    tick();
    res_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},    32'(ready),    32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
    check({tag, "_full"},     32'(full),     32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_res_cnt"},  32'(res_cnt),  32'd0);
  endtask

  initial begin
    // Reset and warm-up; a tag injected during warm-up must vanish
    repeat (2) tick();
    check_all_zero("rst");
    rst = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1;
    tick();                              // edge 5
    in_valid = 1'b0;
    repeat (3) tick();
    res_in = 5'b01110;
    tick();                              // edge 9
    res_in = '0;
    check("warm_drop_rd_valid", 32'(rd_valid), 32'd0);
    check("warm_drop_res_cnt",  32'(res_cnt),  32'd0);
    check("warm_drop_overflow", 32'(overflow), 32'd0);
    repeat (10) tick();                  // edge 19
    check("ready_edge19", 32'(ready), 32'd0);
    tick();                              // edge 20
    check("ready_edge20", 32'(ready), 32'd1);

    // Two results, then FWFT pops in order
    inject(4'd14, 4'd0, 1'b0, 1'b0, '0);
    check("r1_rd_valid", 32'(rd_valid), 32'd1);
    check("r1_rd_data",  32'(rd_data),  32'h0E);
    check("r1_res_cnt",  32'(res_cnt),  32'd1);
    inject(4'd15, 4'd3, 1'b1, 1'b0, '0);
    check("r2_head",    32'(rd_data), 32'h0E);
    check("r2_res_cnt", 32'(res_cnt), 32'd2);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop1_rd_data",  32'(rd_data),  32'h13);
    check("pop1_rd_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b1;
    tick();
    check("pop2_rd_valid", 32'(rd_valid), 32'd0);
    check("pop2_rd_data",  32'(rd_data),  32'd0);
    tick();                              // pop while empty
    rd_en = 1'b0;
    check("empty_pop_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_pop_res_cnt",  32'(res_cnt),  32'd2);

    // Ten back-to-back results (value idx+1); 9th dropped, 10th with a pop
    for (int t = 0; t < 14; t++) begin
      in_valid = (t < 10);
`ifdef KSA4_CAP_CHECK_EN
      a_in   = 4'(t);
      b_in   = 4'd1;
      cin_in = 1'b0;
`endif
      res_in = (t >= 4) ? exp_sum(4'(t - 4), 4'd1, 1'b0) : '0;
      rd_en  = (t == 13);
      tick();
      if (t == 10) check("burst7_full", 32'(full), 32'd0);
      if (t == 11) begin
        check("burst8_full",     32'(full),     32'd1);
        check("burst8_res_cnt",  32'(res_cnt),  32'd10);
        check("burst8_overflow", 32'(overflow), 32'd0);
      end
      if (t == 12) begin
        check("burst9_overflow", 32'(overflow), 32'd1);
        check("burst9_res_cnt",  32'(res_cnt),  32'd10);
        check("burst9_full",     32'(full),     32'd1);
      end
      if (t == 13) begin
        check("burst10_full",    32'(full),    32'd1);
        check("burst10_res_cnt", 32'(res_cnt), 32'd11);
        check("burst10_head",    32'(rd_data), 32'd2);
      end
    end
    in_valid = 1'b0;
    res_in   = '0;
    rd_en    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(rd_data), 32'(drain_exp[i]));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check("drained_rd_valid", 32'(rd_valid), 32'd0);
    check("drained_full",     32'(full),     32'd0);
    check("sticky_overflow",  32'(overflow), 32'd1);
`ifdef KSA4_CAP_CHECK_EN
    check("no_mism_cnt", 32'(mism_cnt), 32'd0);
`endif

    // Three queued, one tag in flight, then a mid-cycle reset
    inject(4'd1, 4'd1, 1'b0, 1'b0, '0);
    inject(4'd2, 4'd2, 1'b0, 1'b0, '0);
    inject(4'd3, 4'd3, 1'b0, 1'b0, '0);
    check("q3_res_cnt", 32'(res_cnt), 32'd14);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    res_in = 5'h1F;
    repeat (4) tick();
    res_in = '0;
    repeat (15) tick();                  // edge 19
    check("rerst_ready19",    32'(ready),    32'd0);
    check("rerst_rd_valid",   32'(rd_valid), 32'd0);
    check("rerst_res_cnt",    32'(res_cnt),  32'd0);
    tick();                              // edge 20
    check("rerst_ready20", 32'(ready), 32'd1);
    res_in = 5'h1F;                      // result bits without a valid tag
    repeat (3) tick();
    res_in = '0;
    check("novalid_rd_valid", 32'(rd_valid), 32'd0);
    check("novalid_res_cnt",  32'(res_cnt),  32'd0);

`ifdef KSA4_CAP_CHECK_EN
    check("pre_mism",     32'(mism),     32'd0);
    check("pre_mism_cnt", 32'(mism_cnt), 32'd0);
    inject(4'd15, 4'd3, 1'b1, 1'b1, 5'b10010);
    check("mism_pulse",   32'(mism),     32'd1);
    check("mism_cnt",     32'(mism_cnt), 32'd1);
    check("mism_stored",  32'(rd_data),  32'h12);
    check("mism_res_cnt", 32'(res_cnt),  32'd1);
    tick();
    check("mism_end",     32'(mism),     32'd0);
    check("mism_cnt_hold", 32'(mism_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
